// File: rtl/zorro_buffer_sequencer.sv
// Zorro bus buffer sequencer: drives the address/data buffer enables and
// direction strobes of a Zorro card for slave accesses and card-mastered
// (DMA) cycles, stepping IDLE -> ADDR -> DATA -> TURN -> IDLE.
module zorro_buffer_sequencer #(
  parameter int                          ADDR_W      = 7,
  parameter int                          NUM_WIN     = 1,
  parameter logic [NUM_WIN*ADDR_W-1:0]   WIN_BASE    = 7'h20,
  parameter logic [NUM_WIN*ADDR_W-1:0]   WIN_LIMIT   = 7'h22,
  parameter int                          ADDR_SETUP  = 1,
  parameter int                          TURN_CYCLES = 2
) (
  input  logic               CLK,
  input  logic               RESET_n,
  input  logic               READ,
  input  logic               slave_cycle,
  input  logic               configured,
  input  logic               BMASTER,
  input  logic               MASTER_n,
  input  logic [ADDR_W-1:0]  ADDR,
  input  logic               FCS_n,
  output logic               DBOE_n,
  output logic               ABOEL_n,
  output logic               ABOEH_n,
  output logic               ADIR,
  output logic               D2Z_n,
  output logic               Z2D_n,
  output logic [NUM_WIN-1:0] WIN_HIT,
  output logic               BUSY
);

  // One shared counter serves both the setup and the turnaround phases.
  localparam int CNT_MAX = (ADDR_SETUP > TURN_CYCLES) ? ADDR_SETUP : TURN_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(ADDR_SETUP - 1);
  localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(TURN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_TURN = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               master_r, master_s;
  logic               read_r, read_s;
  logic [NUM_WIN-1:0] win_r, win_s;
  logic [NUM_WIN-1:0] hit_s, first_hit_s;
  logic               found_s;
  logic               master_go_s, slave_go_s;
  logic               dboe_s, aboe_s, adir_s, d2z_s, z2d_s, busy_s;
  logic [NUM_WIN-1:0] win_out_s;

  // Window decode and lowest-index priority pick.
  always_comb begin
    hit_s       = '0;
    first_hit_s = '0;
    found_s     = 1'b0;
    for (int i = 0; i < NUM_WIN; i++) begin
      hit_s[i]       = (ADDR >= WIN_BASE[i*ADDR_W +: ADDR_W]) &&
                       (ADDR <  WIN_LIMIT[i*ADDR_W +: ADDR_W]);
      first_hit_s[i] = hit_s[i] & ~found_s;
      found_s        = found_s | hit_s[i];
    end
  end

  // Start qualifiers; a master start outranks any slave start.
  always_comb begin
    master_go_s = BMASTER && !MASTER_n && !FCS_n;
    slave_go_s  = !BMASTER && configured && slave_cycle && !FCS_n && (|hit_s);
  end

  // Next-state, counter and latched cycle attributes.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    master_s = master_r;
    read_s   = read_r;
    win_s    = win_r;
    case (state_r)
      ST_IDLE: begin
        cnt_s    = '0;
        master_s = 1'b0;
        read_s   = 1'b0;
        win_s    = '0;
        if (master_go_s) begin
          state_s  = ST_ADDR;
          master_s = 1'b1;
          read_s   = READ;
        end else if (slave_go_s) begin
          state_s  = ST_ADDR;
          read_s   = READ;
          win_s    = first_hit_s;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (FCS_n) begin
          // Strobe withdrawn before data: abandon without opening buffers.
          state_s  = ST_IDLE;
          cnt_s    = '0;
          master_s = 1'b0;
          read_s   = 1'b0;
          win_s    = '0;
        end else if (cnt_r == SETUP_LAST) begin
          state_s = ST_DATA;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (FCS_n) begin
          state_s = ST_TURN;
          cnt_s   = '0;
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_TURN: begin
        if (cnt_r == TURN_LAST) begin
          state_s  = ST_IDLE;
          cnt_s    = '0;
          master_s = 1'b0;
          read_s   = 1'b0;
          win_s    = '0;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s  = ST_IDLE;
        cnt_s    = '0;
        master_s = 1'b0;
        read_s   = 1'b0;
        win_s    = '0;
      end
    endcase
  end

  // Output values for the upcoming state, so the registered outputs line up with it.
  always_comb begin
    dboe_s    = 1'b1;
    aboe_s    = 1'b1;
    adir_s    = 1'b0;
    d2z_s     = 1'b1;
    z2d_s     = 1'b1;
    busy_s    = (state_s != ST_IDLE);
    win_out_s = (state_s != ST_IDLE) ? win_s : '0;
    case (state_s)
      ST_ADDR: begin
        aboe_s = 1'b0;
        adir_s = master_s;
      end
      ST_DATA: begin
        aboe_s = 1'b0;
        adir_s = master_s;
        dboe_s = 1'b0;
        // Slave read and master write both push card data onto Zorro;
        // the two strobes are complements so they can never overlap.
        d2z_s  = ~(master_s ^ read_s);
        z2d_s  = master_s ^ read_s;
      end
      default: begin
        dboe_s = 1'b1;
      end
    endcase
  end

  // State, counter and latched attributes.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      master_r <= 1'b0;
      read_r   <= 1'b0;
      win_r    <= '0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      master_r <= master_s;
      read_r   <= read_s;
      win_r    <= win_s;
    end
  end

  // Registered buffer controls.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      DBOE_n  <= 1'b1;
      ABOEL_n <= 1'b1;
      ABOEH_n <= 1'b1;
      ADIR    <= 1'b0;
      D2Z_n   <= 1'b1;
      Z2D_n   <= 1'b1;
      WIN_HIT <= '0;
      BUSY    <= 1'b0;
    end else begin
      DBOE_n  <= dboe_s;
      ABOEL_n <= aboe_s;
      ABOEH_n <= aboe_s;
      ADIR    <= adir_s;
      D2Z_n   <= d2z_s;
      Z2D_n   <= z2d_s;
      WIN_HIT <= win_out_s;
      BUSY    <= busy_s;
    end
  end

endmodule

// File: doc/zorro_buffer_sequencer.md
ZORRO_BUFFER_SEQUENCER -- requirements
Module: zorro_buffer_sequencer

Interface
REQ-001 SHALL have the following parameters:
- ADDR_W, default 7: width of the decoded address slice, Zorro A[23:24-ADDR_W].
- NUM_WIN, default 1: number of slave decode windows, range 1..4.
- WIN_BASE, default 7'h20: packed NUM_WIN*ADDR_W inclusive window bases; window i occupies slice [i*ADDR_W +: ADDR_W].
- WIN_LIMIT, default 7'h22: packed NUM_WIN*ADDR_W exclusive window limits; a window with BASE >= LIMIT is disabled.
- ADDR_SETUP, default 1: cycles in ADDR before data buffers open, minimum 1.
- TURN_CYCLES, default 2: dead cycles with data buffers closed after a data phase, minimum 1.
REQ-002 SHALL have these ports:
- CLK  in  1  sole clock; all state changes on rising edge.
- RESET_n  in  1  asynchronous, active-low reset.
- READ  in  1  1 = Zorro read cycle.
- slave_cycle  in  1  Zorro slave cycle in progress.
- configured  in  1  board autoconfigured.
- BMASTER  in  1  card owns the bus (DMA).
- MASTER_n  in  1  active-low, card master cycle strobe.
- ADDR  in  ADDR_W  decoded address slice.
- FCS_n  in  1  active-low Zorro full cycle strobe.
- DBOE_n  out  1  active-low data buffer enable.
- ABOEL_n  out  1  active-low low address buffer enable.
- ABOEH_n  out  1  active-low high address buffer enable.
- ADIR  out  1  0 = Zorro->card address, 1 = card->Zorro address.
- D2Z_n  out  1  active-low, data card->Zorro.
- Z2D_n  out  1  active-low, data Zorro->card.
- WIN_HIT  out  NUM_WIN  one-hot latched window, slave cycles only.
- BUSY  out  1  state != IDLE.

Function
REQ-003 SHALL register every output; no combinational input-to-output path.
REQ-004 SHALL implement states IDLE, ADDR, DATA and TURN.
REQ-005 Window i hit SHALL be ADDR >= BASE_i && ADDR < LIMIT_i, compared unsigned at ADDR_W bits.
REQ-006 Master start SHALL be BMASTER=1 && MASTER_n=0 && FCS_n=0, sampled in IDLE.
REQ-007 Slave start SHALL be BMASTER=0 && configured && slave_cycle && FCS_n=0 && any window hit, sampled in IDLE.
REQ-008 A master start SHALL take priority over a slave start in the same cycle; slave starts are ignored while BMASTER=1.
REQ-009 On start, the block SHALL enter ADDR and latch:
- mode: master or slave;
- direction from READ;
- WIN_HIT as the lowest-index hitting window, or all-zero for a master start.
REQ-010 Latched values SHALL hold until return to IDLE; READ and ADDR changes mid-cycle are ignored.
REQ-011 In ADDR and DATA, ABOEL_n and ABOEH_n SHALL be 0; ADIR SHALL be 1 for master mode and 0 for slave mode.
REQ-012 ADDR SHALL last exactly ADDR_SETUP cycles and then enter DATA.
REQ-013 In DATA, DBOE_n SHALL be 0, with direction as follows:
- slave read: D2Z_n=0, Z2D_n=1;
- slave write: Z2D_n=0, D2Z_n=1;
- master read: Z2D_n=0, D2Z_n=1;
- master write: D2Z_n=0, Z2D_n=1.
REQ-014 D2Z_n and Z2D_n SHALL never both be 0 in any cycle.
REQ-015 DBOE_n SHALL be 0 only in DATA.
REQ-016 FCS_n=1 sampled in DATA SHALL enter TURN.
REQ-017 FCS_n=1 sampled in ADDR SHALL abort directly to IDLE; no data enable occurs.
REQ-018 In TURN, DBOE_n, D2Z_n, Z2D_n, ABOEL_n and ABOEH_n SHALL all be 1; TURN lasts exactly TURN_CYCLES cycles, then IDLE.
REQ-019 A new start SHALL be accepted only in IDLE; a start pending during TURN is sampled on the first IDLE cycle.
REQ-020 In IDLE, WIN_HIT SHALL be all-zero and ADIR SHALL be 0.
REQ-021 Setup and turn counters SHALL be wide enough for the respective parameter and SHALL not wrap.

Reset
REQ-022 RESET_n=0 SHALL immediately force:
- state IDLE and counters 0;
- DBOE_n, ABOEL_n, ABOEH_n, D2Z_n and Z2D_n to 1;
- ADIR, WIN_HIT and BUSY to 0.
REQ-023 Reset asserted mid-cycle, in any state, SHALL abort the cycle; no TURN is required after release.
REQ-024 After RESET_n rises, the first start SHALL be sampled on the next rising CLK.

Verification
REQ-025 The bench SHALL cover these directed scenarios with defaults unless stated:
- Slave read, ADDR=7'h21, FCS_n low for 6 cycles -> ABOE low at edge 1, DBOE_n/D2Z_n low at edge 2, TURN 2 cycles after FCS_n rises, then IDLE; WIN_HIT=1.
- Slave write, ADDR=7'h22 -> no start, all outputs inactive; with ADDR=7'h20 -> Z2D_n low in DATA.
- NUM_WIN=2 with windows 20-22 and 21-30, ADDR=7'h21 -> WIN_HIT=2'b01.
- Master write: BMASTER=1, MASTER_n=0, READ=0, plus a simultaneous slave qualifier -> ADIR=1, D2Z_n low, WIN_HIT=0.
- Read immediately followed by a write, FCS_n re-asserted during TURN -> DATA directions never overlap; the write starts only after IDLE.
- RESET_n pulsed low in DATA -> all enables 1 asynchronously; FCS_n rising in ADDR -> straight to IDLE with DBOE_n never 0.
